// File: rtl/mgmt_flash_sequencer.sv
// Minimal management core: fetches 32-bit command words from SPI flash (READ 0x03,
// single-bit, mode 0, SCK = core_clk/2) and drives the management GPIO pad and LA banks.
module mgmt_flash_sequencer #(
  parameter logic [23:0] RESET_ADDR = 24'h000000,
  parameter int unsigned WAIT_W     = 24
) (
  input  logic        core_clk,
  input  logic        core_rst,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0_do,
  output logic        flash_io0_oeb,
  input  logic        flash_io1_di,
  output logic        gpio_out_pad,
  output logic        gpio_outenb_pad,
  input  logic        gpio_in_pad,
  output logic [63:0] la_output,
  output logic [63:0] la_oenb,
  output logic        trap
);

  typedef enum logic [2:0] {
    S_GAP,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_EXEC,
    S_WAIT,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_GPIO   = 4'h1;
  localparam logic [3:0] OP_LAOUT  = 4'h2;
  localparam logic [3:0] OP_LAOEN  = 4'h3;
  localparam logic [3:0] OP_WAIT   = 4'h4;
  localparam logic [3:0] OP_JUMP   = 4'h5;
  localparam logic [3:0] OP_SKIPIF = 4'h6;
  localparam logic [7:0] READ_CMD  = 8'h03;

  state_t            state, state_next;
  logic              gap_done;
  logic [4:0]        bit_cnt;
  logic [30:0]       shift_reg;
  logic [31:0]       word;
  logic [23:0]       pc;
  logic [WAIT_W-1:0] wait_cnt;
  logic              skip;

  logic [3:0]        opcode;
  logic [1:0]        lane;
  logic [WAIT_W-1:0] wait_len;
  logic [31:0]       cmd_word;
  logic              unused_word_bits;

  assign opcode           = word[31:28];
  assign lane             = word[25:24];
  assign wait_len         = word[WAIT_W-1:0];
  assign cmd_word         = {READ_CMD, pc};
  assign unused_word_bits = ^word[27:26];
  assign flash_io0_oeb    = 1'b0;

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) state <= S_GAP;
    else          state <= state_next;
  end

  // A shift state ends on the cycle SCK falls after its last bit.
  always_comb begin
    state_next = state;
    unique case (state)
      S_GAP:  if (gap_done) state_next = S_CMD;
      S_CMD:  if (flash_clk && bit_cnt == 5'd7)  state_next = S_ADDR;
      S_ADDR: if (flash_clk && bit_cnt == 5'd31) state_next = S_DATA;
      S_DATA: if (flash_clk && bit_cnt == 5'd31) state_next = S_EXEC;
      S_EXEC: begin
        if (skip) begin
          state_next = S_DATA;
        end else begin
          case (opcode)
            OP_NOP, OP_GPIO, OP_LAOUT, OP_LAOEN, OP_SKIPIF: state_next = S_DATA;
            OP_WAIT: state_next = (wait_len == '0) ? S_DATA : S_WAIT;
            OP_JUMP: state_next = S_GAP;
            default: state_next = S_HALT;
          endcase
        end
      end
      S_WAIT: if (wait_cnt <= WAIT_W'(1)) state_next = S_DATA;
      S_HALT: state_next = S_HALT;
      default: state_next = S_GAP;
    endcase
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      gap_done        <= 1'b0;
      bit_cnt         <= '0;
      shift_reg       <= '0;
      word            <= '0;
      pc              <= RESET_ADDR;
      wait_cnt        <= '0;
      skip            <= 1'b0;
      flash_csb       <= 1'b1;
      flash_clk       <= 1'b0;
      flash_io0_do    <= 1'b0;
      gpio_out_pad    <= 1'b0;
      gpio_outenb_pad <= 1'b1;
      la_output       <= '0;
      la_oenb         <= '1;
      trap            <= 1'b0;
    end else begin
      unique case (state)
        S_GAP: begin
          gap_done <= ~gap_done;
          if (gap_done) begin
            flash_csb    <= 1'b0;
            flash_io0_do <= cmd_word[31];
            shift_reg    <= cmd_word[30:0];
            bit_cnt      <= '0;
          end
        end
        // Each bit: SCK low cycle (MOSI already set), then SCK high cycle.
        S_CMD, S_ADDR, S_DATA: begin
          flash_clk <= ~flash_clk;
          if (!flash_clk) begin
            if (state == S_DATA)
              word[{bit_cnt[4:3], ~bit_cnt[2:0]}] <= flash_io1_di;
          end else begin
            bit_cnt      <= bit_cnt + 5'd1;
            flash_io0_do <= shift_reg[30];
            shift_reg    <= {shift_reg[29:0], 1'b0};
          end
        end
        S_EXEC: begin
          pc   <= pc + 24'd4;
          skip <= 1'b0;
          if (!skip) begin
            case (opcode)
              OP_NOP: ;
              OP_GPIO: begin
                gpio_out_pad    <= word[0];
                gpio_outenb_pad <= word[1];
              end
              OP_LAOUT: la_output[{lane, 4'b0000} +: 16] <= word[15:0];
              OP_LAOEN: la_oenb[{lane, 4'b0000} +: 16]   <= word[15:0];
              OP_WAIT:  wait_cnt <= wait_len;
              OP_JUMP: begin
                pc        <= {word[23:2], 2'b00};
                flash_csb <= 1'b1;
              end
              OP_SKIPIF: skip <= (gpio_in_pad == word[0]);
              default: begin
                flash_csb <= 1'b1;
                trap      <= 1'b1;
              end
            endcase
          end
        end
        S_WAIT: wait_cnt <= wait_cnt - WAIT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mgmt_flash_sequencer.sv
// Bench for mgmt_flash_sequencer: SPI flash model plus an instruction-level reference
// model that predicts per-word execute times and output values.
module tb_mgmt_flash_sequencer;

  logic        core_clk = 1'b0;
  logic        core_rst = 1'b0;
  logic        flash_csb, flash_clk, flash_io0_do, flash_io0_oeb;
  logic        flash_io1_di = 1'b0;
  logic        gpio_out_pad, gpio_outenb_pad;
  logic        gpio_in_pad = 1'b0;
  logic [63:0] la_output, la_oenb;
  logic        trap;

  mgmt_flash_sequencer dut (
    .core_clk        (core_clk),
    .core_rst        (core_rst),
    .flash_csb       (flash_csb),
    .flash_clk       (flash_clk),
    .flash_io0_do    (flash_io0_do),
    .flash_io0_oeb   (flash_io0_oeb),
    .flash_io1_di    (flash_io1_di),
    .gpio_out_pad    (gpio_out_pad),
    .gpio_outenb_pad (gpio_outenb_pad),
    .gpio_in_pad     (gpio_in_pad),
    .la_output       (la_output),
    .la_oenb         (la_oenb),
    .trap            (trap)
  );

  always #5 core_clk = ~core_clk;

  typedef struct {
    int           t;
    logic [130:0] outv;
  } step_t;

  localparam logic [134:0] RST_VEC  = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, {64{1'b1}}};
  localparam logic [130:0] RST_CORE = {1'b0, 1'b1, 1'b0, 64'h0, {64{1'b1}}};

  logic [7:0]  mem [0:255];
  step_t       exp_q[$];
  logic [23:0] exp_fetch[$];
  logic [31:0] fl_log[$];
  int          check_cnt = 0;
  int          pass_cnt  = 0;
  int          fail_cnt  = 0;
  int          cyc       = 0;

  // SPI flash: 32 command/address bits in on rising SCK, data out after each falling SCK.
  int          fl_bits = 0;
  int          fl_out  = 0;
  logic [31:0] fl_in   = '0;

  always @(posedge flash_clk or posedge flash_csb) begin
    if (flash_csb) begin
      fl_bits = 0;
    end else if (fl_bits < 32) begin
      fl_in = {fl_in[30:0], flash_io0_do};
      fl_bits++;
      if (fl_bits == 32) fl_log.push_back(fl_in);
    end
  end

  always @(negedge flash_clk) begin : fl_out_blk
    logic [7:0] b;
    if (flash_csb || fl_bits < 32) begin
      fl_out = 0;
    end else begin
      #1;
      b = mem[8'(fl_in[7:0] + 8'(fl_out / 8))];
      flash_io1_di = b[7 - (fl_out % 8)];
      fl_out++;
    end
  end

  // GPIO pulse monitor for the blink loop.
  int   falls = 0, high_len = 0, min_high = 1000000;
  logic prev_g = 1'b0;
  always @(negedge core_clk) begin
    if (core_rst) begin
      falls = 0; high_len = 0; min_high = 1000000; prev_g = 1'b0;
    end else begin
      if (gpio_out_pad) high_len++;
      if (prev_g && !gpio_out_pad) begin
        falls++;
        if (high_len < min_high) min_high = high_len;
        high_len = 0;
      end
      prev_g = gpio_out_pad;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [134:0] obs_all();
    return {flash_csb, flash_clk, flash_io0_do, flash_io0_oeb, gpio_out_pad, gpio_outenb_pad,
            trap, la_output, la_oenb};
  endfunction

  function automatic logic [130:0] obs_core();
    return {gpio_out_pad, gpio_outenb_pad, trap, la_output, la_oenb};
  endfunction

  task automatic check_output(input string tag, input logic [134:0] observed,
                              input logic [134:0] expected);
    check_cnt++;
    assert (observed === expected) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge core_clk);
    #1;
    cyc++;
  endtask

  task automatic put_word(input int addr, input logic [31:0] w);
    for (int k = 0; k < 4; k++) mem[(addr + k) % 256] = w[8*k +: 8];
  endtask

  task automatic fill_halt();
    for (int a = 0; a < 256; a += 4) put_word(a, 32'hF000_0000);
  endtask

  // Instruction-level model: first execute 130 cycles after reset release, sequential
  // words 65 apart, WAIT n adds n, JUMP restarts with a 2-cycle gap plus a full READ.
  task automatic build_model(input int max_steps, output bit halted);
    int          t, next_t, lane;
    logic [23:0] pc, next_pc;
    logic [7:0]  a;
    logic [31:0] w;
    bit          skip;
    logic        go, ge, trp;
    logic [63:0] lo, le;
    t = 130; pc = 24'h0; skip = 0; halted = 0;
    go = 1'b0; ge = 1'b1; trp = 1'b0; lo = '0; le = '1;
    exp_q.delete();
    exp_fetch.delete();
    exp_fetch.push_back(24'h0);
    for (int n = 0; n < max_steps && !halted; n++) begin
      a = pc[7:0];
      w = {mem[8'(a + 8'd3)], mem[8'(a + 8'd2)], mem[8'(a + 8'd1)], mem[a]};
      lane = int'(w[25:24]);
      next_t = t + 65;
      next_pc = pc + 24'd4;
      if (skip) begin
        skip = 0;
      end else begin
        case (w[31:28])
          4'h0: ;
          4'h1: begin go = w[0]; ge = w[1]; end
          4'h2: lo[lane*16 +: 16] = w[15:0];
          4'h3: le[lane*16 +: 16] = w[15:0];
          4'h4: next_t = t + 65 + int'(w[23:0]);
          4'h5: begin
            next_pc = w[23:0] & 24'hFFFFFC;
            next_t = t + 131;
            exp_fetch.push_back(next_pc);
          end
          4'h6: skip = (gpio_in_pad == w[0]);
          default: begin trp = 1'b1; halted = 1; end
        endcase
      end
      exp_q.push_back('{t, {go, ge, trp, lo, le}});
      t = next_t;
      pc = next_pc;
    end
  endtask

  task automatic run_program(input string name, input int max_steps);
    bit           halted;
    int           bad;
    logic [130:0] prev;
    build_model(max_steps, halted);
    core_rst = 1'b1;
    #3;
    check_output({name, "_rst"}, obs_all(), RST_VEC);
    tick();
    tick();
    fl_log.delete();
    core_rst = 1'b0;
    cyc = 0;
    prev = RST_CORE;
    foreach (exp_q[i]) begin
      while (cyc < exp_q[i].t) tick();
      check_output($sformatf("%s_s%0d_pre", name, i), obs_core(), prev);
      tick();
      check_output($sformatf("%s_s%0d_post", name, i), obs_core(), exp_q[i].outv);
      prev = exp_q[i].outv;
    end
    if (halted) begin
      check_output({name, "_halt_csb"}, flash_csb, 1);
      bad = 0;
      for (int k = 0; k < 20; k++) begin
        tick();
        if (flash_clk !== 1'b0 || flash_csb !== 1'b1) bad++;
      end
      check_output({name, "_halt_idle"}, 135'(bad), 135'(0));
      check_output({name, "_halt_hold"}, obs_core(), prev);
    end
    check_output({name, "_fetch_cnt"}, 135'(fl_log.size() >= exp_fetch.size()), 135'(1));
    foreach (exp_fetch[k])
      if (k < fl_log.size())
        check_output($sformatf("%s_fetch%0d", name, k), fl_log[k], {8'h03, exp_fetch[k]});
  endtask

  task automatic gen_random_program(input int len);
    logic [31:0] w;
    int          op;
    fill_halt();
    for (int i = 0; i < len - 1; i++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: w = {4'h0, 28'($urandom)};
        1: w = {4'h1, 28'($urandom)};
        2: w = {4'h2, 28'($urandom)};
        3: w = {4'h3, 28'($urandom)};
        4: w = {4'h4, 4'($urandom), 24'($urandom_range(0, 15))};
        default: w = {4'h6, 28'($urandom)};
      endcase
      put_word(4 * i, w);
    end
    put_word(4 * (len - 1), {4'($urandom_range(7, 15)), 28'($urandom)});
    gpio_in_pad = 1'($urandom);
  endtask

  initial begin
    #1;

    fill_halt();
    put_word(0, 32'h3100_0000);
    put_word(4, 32'h2100_AB12);
    put_word(8, 32'hF000_0000);
    run_program("la", 10);
    check_output("la_output", la_output, 64'h0000_0000_AB12_0000);
    check_output("la_oenb", la_oenb, 64'hFFFF_FFFF_0000_FFFF);

    core_rst = 1'b1;
    tick();
    tick();
    core_rst = 1'b0;
    cyc = 0;
    while (cyc < 230) tick();
    check_output("mid_pre_oenb", la_oenb, 64'hFFFF_FFFF_0000_FFFF);
    check_output("mid_pre_csb", flash_csb, 0);
    #2;
    core_rst = 1'b1;
    #1;
    check_output("mid_rst", obs_all(), RST_VEC);
    run_program("la_after_rst", 10);

    fill_halt();
    put_word(32'h00, 32'h1000_0001);
    put_word(32'h04, 32'h5000_0043);
    put_word(32'h08, 32'h1000_0003);
    put_word(32'h40, 32'h2200_1234);
    put_word(32'h44, 32'hF000_0000);
    run_program("jump", 10);

    fill_halt();
    put_word(0, 32'h1000_0002);
    put_word(4, 32'h7123_4567);
    run_program("illegal", 10);

    fill_halt();
    gpio_in_pad = 1'b1;
    put_word(0,  32'h6000_0001);
    put_word(4,  32'h1000_0001);
    put_word(8,  32'h6000_0000);
    put_word(12, 32'h1000_0003);
    put_word(16, 32'hF000_0000);
    run_program("skipif", 10);

    for (int r = 0; r < 6; r++) begin
      gen_random_program(14);
      run_program($sformatf("rand%0d", r), 40);
    end

    fill_halt();
    put_word(0,  32'h1000_0003);
    put_word(4,  32'h4000_00C8);
    put_word(8,  32'h1000_0002);
    put_word(12, 32'h4000_00C8);
    put_word(16, 32'h5000_0000);
    run_program("blink", 51);
    check_output("blink_falls", 135'(falls >= 10), 135'(1));
    check_output("blink_high", 135'(min_high >= 201), 135'(1));

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
